ahb3lite_interconnect_slave_arbiter: RTL

AHB3LITE_INTERCONNECT_SLAVE_ARBITER -- requirements
Module: ahb3lite_interconnect_slave_arbiter

---
 rtl/ahb3lite_interconnect_slave_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// ahb3lite_interconnect_slave_arbiter
//   Chooses which master owns one AHB3-Lite slave port. The grant is registered
//   and one-hot. Once a master is granted, it keeps the slave for the whole of a
//   fixed-length burst, an undefined-length INCR burst, or a locked sequence.
//   Otherwise the grant goes to the best candidate whenever HREADY=1.
//
// Ports
//   HCLK         in   block clock (rising edge)
//   HRESET       in   asynchronous active-high reset
//   HSEL         in   [MASTERS]                 per-master select for this slave
//   priority_i   in   [MASTERS*PRIORITY_BITS]   per-master priority, master i at slice i
//   priority_max in   [PRIORITY_BITS]           highest priority among selected masters
//   HTRANS       in   [MASTERS*2]               per-master transfer type, master i at slice i
//   HBURST       in   [MASTERS*3]               per-master burst type, master i at slice i
//   HMASTLOCK    in   [MASTERS]                 per-master lock
//   HREADY       in   slave-side ready; decisions are taken only when high
//   grant        out  [MASTERS]                 one-hot registered grant
//   master_sel   out  [MS_BITS]                 binary index of the granted master
//
// Build option
//   AHB3LITE_INTERCONNECT_ROUND_ROBIN_EN : round-robin among equal-priority
//   candidates. When it is not defined, the lowest index wins.
//
// state | meaning
// ARB   | free to arbitrate at the next HREADY=1
// BURST | fixed-length burst in progress, cnt = SEQ beats still to come
// INCR  | undefined-length INCR burst in progress
// LOCK  | locked sequence in progress
module ahb3lite_interconnect_slave_arbiter #(
  parameter int MASTERS       = 3,
  parameter int PRIORITY_BITS = $clog2(MASTERS+1),
  localparam int MS_BITS      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                               HCLK,
  input  logic                               HRESET,
  input  logic [MASTERS-1:0]                 HSEL,
  input  logic [MASTERS*PRIORITY_BITS-1:0]   priority_i,
  input  logic [PRIORITY_BITS-1:0]           priority_max,
  input  logic [2*MASTERS-1:0]               HTRANS,
  input  logic [3*MASTERS-1:0]               HBURST,
  input  logic [MASTERS-1:0]                 HMASTLOCK,
  input  logic                               HREADY,
  output logic [MASTERS-1:0]                 grant,
  output logic [MS_BITS-1:0]                 master_sel
);

  typedef enum logic [1:0] {ARB, BURST, INCR, LOCK} state_t;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] HB_INCR   = 3'd1;

  state_t               state, state_nxt, arb_state;
  logic [3:0]           cnt, cnt_nxt, arb_cnt;
  logic [MS_BITS-1:0]   sel_nxt, arb_sel, win_idx;
  logic [MASTERS-1:0]   cand, grant_nxt;
  logic                 win_found;
  logic [1:0]           cur_trans;
  logic [2:0]           cur_burst;
  logic                 cur_lock;

  assign cur_trans = HTRANS[int'(master_sel)*2 +: 2];
  assign cur_burst = HBURST[int'(master_sel)*3 +: 3];
  assign cur_lock  = HMASTLOCK[master_sel];

  always_comb begin
    for (int i = 0; i < MASTERS; i++)
      cand[i] = HSEL[i] && (priority_i[i*PRIORITY_BITS +: PRIORITY_BITS] == priority_max);
  end

`ifdef AHB3LITE_INTERCONNECT_ROUND_ROBIN_EN
  logic [MS_BITS-1:0] rr_ptr;

  // Search starts just after the last granted master and wraps to 0.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= MASTERS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= MASTERS) idx = idx - MASTERS;
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = MS_BITS'(idx);
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                     rr_ptr <= '0;
    else if (sel_nxt != master_sel) rr_ptr <= sel_nxt;
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = MASTERS-1; i >= 0; i--) begin
      if (cand[i]) begin
        win_found = 1'b1;
        win_idx   = MS_BITS'(i);
      end
    end
  end
`endif

  // What an arbitration point would decide. BURST, INCR and LOCK fall back on
  // this whenever their hold condition ends.
  always_comb begin
    arb_state = ARB;
    arb_cnt   = 4'd0;
    arb_sel   = master_sel;
    if (cur_trans == TR_NONSEQ && cur_lock) begin
      arb_state = LOCK;
    end else if (cur_trans == TR_NONSEQ && cur_burst > HB_INCR) begin
      arb_state = BURST;
      case (cur_burst)
        3'd2, 3'd3: arb_cnt = 4'd3;
        3'd4, 3'd5: arb_cnt = 4'd7;
        default:    arb_cnt = 4'd15;
      endcase
    end else if (cur_trans == TR_NONSEQ && cur_burst == HB_INCR) begin
      arb_state = INCR;
    end else if (win_found) begin
      arb_sel = win_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = master_sel;
    if (HREADY) begin
      case (state)
        ARB: begin
          state_nxt = arb_state; cnt_nxt = arb_cnt; sel_nxt = arb_sel;
        end
        BURST: begin
          if (cur_trans == TR_SEQ) begin
            // The last beat (cnt<=1) re-arbitrates. This also keeps cnt from wrapping.
            if (cnt <= 4'd1) begin
              state_nxt = arb_state; cnt_nxt = arb_cnt; sel_nxt = arb_sel;
            end else begin
              cnt_nxt = cnt - 4'd1;
            end
          end else if (cur_trans != TR_BUSY) begin
            state_nxt = arb_state; cnt_nxt = arb_cnt; sel_nxt = arb_sel;
          end
        end
        INCR: begin
          if (cur_trans == TR_IDLE || cur_trans == TR_NONSEQ) begin
            state_nxt = arb_state; cnt_nxt = arb_cnt; sel_nxt = arb_sel;
          end
        end
        default: begin
          if (!cur_lock) begin
            state_nxt = arb_state; cnt_nxt = arb_cnt; sel_nxt = arb_sel;
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < MASTERS; i++)
      grant_nxt[i] = (sel_nxt == MS_BITS'(i));
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= ARB;
      cnt        <= 4'd0;
      master_sel <= '0;
      grant      <= MASTERS'(1);
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      master_sel <= sel_nxt;
      grant      <= grant_nxt;
    end
  end

endmodule
